// File: rtl/reg_file_mp.sv
// Multi-ported GPR file with per-register pending scoreboard, written on posedge clk.
// Optional write-first read bypass is enabled by defining REG_FILE_BYPASS_EN.
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

module reg_file_mp #(
    parameter int REG_FILE_BITS = 5,
    parameter int REG_SIZE      = `DWORD_BITS,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_FILE_BITS-1:0] read_num    [READ_PORTS],
    output logic [REG_SIZE-1:0]      output_data [READ_PORTS],
    output logic [READ_PORTS-1:0]    read_busy,
    input  logic [WRITE_PORTS-1:0]   we,
    input  logic [REG_FILE_BITS-1:0] write_num   [WRITE_PORTS],
    input  logic [REG_SIZE-1:0]      input_data  [WRITE_PORTS],
    input  logic                     issue_en,
    input  logic [REG_FILE_BITS-1:0] issue_num,
    input  logic                     flush,
    output logic [REG_FILE_BITS:0]   busy_count
);
    localparam int REG_FILE_SIZE = 1 << REG_FILE_BITS;

    logic [REG_SIZE-1:0]      regs_q [REG_FILE_SIZE];
    logic [REG_SIZE-1:0]      regs_d [REG_FILE_SIZE];
    logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
    logic [REG_FILE_BITS:0]   busy_count_q, busy_count_d;

    // Later write ports overwrite earlier ones, so the highest enabled port wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < WRITE_PORTS; j++) begin
            if (we[j] && (write_num[j] != '0)) begin
                regs_d[write_num[j]] = input_data[j];
            end
        end
    end

    // Priority from lowest to highest: writeback clears, issue sets, flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < WRITE_PORTS; j++) begin
            if (we[j]) begin
                busy_d[write_num[j]] = 1'b0;
            end
        end
        if (issue_en) begin
            busy_d[issue_num] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int r = 0; r < REG_FILE_SIZE; r++) begin
            busy_count_d = busy_count_d + {{REG_FILE_BITS{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_FILE_SIZE; r++) begin
                regs_q[r] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // x0 is never written, so the stored array already reads it as zero.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            output_data[i] = regs_q[read_num[i]];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (we[j] && (write_num[j] == read_num[i]) && (read_num[i] != '0)) begin
                    output_data[i] = input_data[j];
                end
            end
`endif
            read_busy[i] = busy_q[read_num[i]];
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: a behavioural model fills expected queues each cycle
// and an independent negedge monitor pops and compares against the DUT outputs.
module tb_reg_file_mp;
  localparam int RB = 5;
  localparam int W  = 32;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int N  = 1 << RB;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RB-1:0] read_num    [RP];
  logic [W-1:0]  output_data [RP];
  logic [RP-1:0] read_busy;
  logic [WP-1:0] we;
  logic [RB-1:0] write_num   [WP];
  logic [W-1:0]  input_data  [WP];
  logic          issue_en;
  logic [RB-1:0] issue_num;
  logic          flush;
  logic [RB:0]   busy_count;

  reg_file_mp #(.REG_FILE_BITS(RB), .REG_SIZE(W), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
    .clk(clk), .rst_n(rst_n), .read_num(read_num), .output_data(output_data),
    .read_busy(read_busy), .we(we), .write_num(write_num), .input_data(input_data),
    .issue_en(issue_en), .issue_num(issue_num), .flush(flush), .busy_count(busy_count)
  );

  // reference model: architectural register contents and pending flags
  logic [W-1:0] m_regs [N];
  bit           m_busy [N];

  // scoreboard
  logic [W-1:0] exp_data_q[$];
  logic [W-1:0] exp_busy_q[$];
  logic [W-1:0] exp_cnt_q[$];
  string        tag_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_read(input int i);
    logic [W-1:0] v;
    v = (read_num[i] == 0) ? '0 : m_regs[read_num[i]];
`ifdef REG_FILE_BYPASS_EN
    for (int j = 0; j < WP; j++)
      if (we[j] && write_num[j] == read_num[i] && read_num[i] != 0) v = input_data[j];
`endif
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int r = 1; r < N; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Applies the clock-edge rules to the model using the inputs held across the edge.
  task automatic model_edge();
    bit nb [N];
    for (int r = 1; r < N; r++) begin
      bit wb = 1'b0;
      for (int j = 0; j < WP; j++) if (we[j] && int'(write_num[j]) == r) wb = 1'b1;
      if (flush)                                nb[r] = 1'b0;
      else if (issue_en && int'(issue_num) == r) nb[r] = 1'b1;
      else if (wb)                              nb[r] = 1'b0;
      else                                      nb[r] = m_busy[r];
    end
    for (int r = 1; r < N; r++) m_busy[r] = nb[r];
    for (int j = 0; j < WP; j++)
      if (we[j] && write_num[j] != 0) m_regs[write_num[j]] = input_data[j];
  endtask

  // driver: expectations for the current inputs, then one clock edge
  task automatic cycle(input string tag);
    for (int i = 0; i < RP; i++) begin
      exp_data_q.push_back(model_read(i));
      exp_busy_q.push_back(W'(m_busy[read_num[i]]));
    end
    exp_cnt_q.push_back(W'(model_count()));
    tag_q.push_back(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = '0;
    issue_en = 1'b0;
    issue_num = '0;
    flush = 1'b0;
    for (int i = 0; i < RP; i++) read_num[i] = '0;
    for (int j = 0; j < WP; j++) begin
      write_num[j] = '0;
      input_data[j] = '0;
    end
  endtask

  // monitor: compares every cycle for which an expectation is queued
  always @(negedge clk) begin
    if (exp_cnt_q.size() != 0) begin
      string t;
      t = tag_q.pop_front();
      for (int i = 0; i < RP; i++) begin
        check($sformatf("%s data[%0d]", t, i), output_data[i], exp_data_q.pop_front());
        check($sformatf("%s busy[%0d]", t, i), W'(read_busy[i]), exp_busy_q.pop_front());
      end
      check($sformatf("%s busy_count", t), W'(busy_count), exp_cnt_q.pop_front());
    end
  end

  initial begin
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("after_reset");

    // write x5, then assert reset mid-run while a write to x6 is pending
    we = 2'b01; write_num[0] = 5; input_data[0] = 32'hDEAD; issue_en = 1'b1; issue_num = 5'd12;
    cycle("wr_x5");
    idle_inputs(); read_num[0] = 5; cycle("rd_x5");
    rst_n = 1'b0;
    model_clear();
    read_num[0] = 5; read_num[1] = 12;
    we = 2'b01; write_num[0] = 6; input_data[0] = 32'h1234;
    cycle("in_reset");
    rst_n = 1'b1;
    idle_inputs(); read_num[0] = 5; read_num[1] = 6; cycle("post_reset");

    // x0 writes and issue marks ignored
    we = 2'b01; write_num[0] = 0; input_data[0] = 32'hFFFF; issue_en = 1'b1; issue_num = 0;
    cycle("x0_wr");
    idle_inputs(); cycle("x0_rd");

    // both ports write x7, highest port wins
    we = 2'b11; write_num[0] = 7; input_data[0] = 32'h11; write_num[1] = 7; input_data[1] = 32'h22;
    cycle("dual_wr_x7");
    idle_inputs(); read_num[0] = 7; cycle("dual_rd_x7");

    // issue then writeback
    issue_en = 1'b1; issue_num = 3; cycle("iss_x3");
    idle_inputs(); read_num[0] = 3; we = 2'b01; write_num[0] = 3; input_data[0] = 32'h5;
    cycle("wb_x3");
    idle_inputs(); read_num[0] = 3; cycle("rd_x3");

    // same-cycle issue and writeback keeps pending; flush beats issue
    issue_en = 1'b1; issue_num = 4; we = 2'b10; write_num[1] = 4; input_data[1] = 32'h44;
    cycle("iss_wb_x4");
    idle_inputs(); read_num[1] = 4; flush = 1'b1; issue_en = 1'b1; issue_num = 9;
    cycle("flush_iss_x9");
    idle_inputs(); read_num[0] = 9; read_num[1] = 4; cycle("after_flush");

    // same-cycle read of the register being written
    we = 2'b01; write_num[0] = 8; input_data[0] = 32'hABCD; read_num[0] = 8;
    cycle("rd_wr_x8");
    idle_inputs(); read_num[1] = 8; cycle("rd_x8");

    // randomised traffic on a narrow index range to force collisions
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < RP; i++)
        read_num[i] = ($urandom_range(0, 3) == 0) ? RB'($urandom_range(0, N - 1)) : RB'($urandom_range(0, 7));
      for (int j = 0; j < WP; j++) begin
        we[j] = ($urandom_range(0, 2) == 0);
        write_num[j] = RB'($urandom_range(0, 7));
        input_data[j] = $urandom;
      end
      issue_en = ($urandom_range(0, 1) == 1);
      issue_num = ($urandom_range(0, 3) == 0) ? RB'($urandom_range(0, N - 1)) : RB'($urandom_range(0, 7));
      flush = ($urandom_range(0, 23) == 0);
      cycle("rand");
    end

    idle_inputs();
    cycle("final");
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_cnt_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_cnt_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
